ctrl_burst_data: RTL and testbench
==================================

# ctrl_burst_data

Data-phase engine of the DDR controller, at the far end of the CAS handshake. It accepts each READ/WRITE command pulse from the CAS scheduler and waits the programmed read latency (AL+CL) or write latency (AL+CWL). It then captures or drives one BL/2-cycle burst on the DQ side and pulses `rw_done` back to the scheduler. Up to four commands may be in flight, because tCCD is shorter than the CAS latency.

## Interface
- `DQ_W`, 8: DQ bus width; two beats per CK cycle (rise/fall).
- `Q_DEPTH`, 4: pending-command queue depth (power of 2).
- `CK_t` in 1: sole clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `cas_rdy` in 1: one-cycle CAS-issued pulse.
- `cas_req` in 3: RD_R/RDA_R/WR_R/WRA_R; valid with `cas_rdy`.
- `CL`, `CWL`, `AL` in 5 each: programmed latencies, sampled at `cas_rdy`.
- `BL` in 4: burst length, 4 or 8, sampled at `cas_rdy`.
- `dq_in` in 2*DQ_W: read beats {fall,rise}.
- `wr_data` in 2*DQ_W: host write beats; valid the cycle after `wr_pop`.
- `rd_data` out 2*DQ_W: captured read beats.
- `rd_valid` out 1: `rd_data` valid.
- `wr_pop` out 1: request the next write word.
- `dq_out` out 2*DQ_W: write beats to PHY.
- `dq_oe` out 1: DQ drive enable.
- `dqs_oe` out 1: DQS drive enable, including a 1-cycle preamble.
- `rw_done` out 1: one-cycle pulse on the last beat of every burst.
- `q_full` out 1: queue holds Q_DEPTH entries.
- `err_ovf` out 1: sticky; `cas_rdy` arrived while full.
- `err_col` out 1: sticky; bursts overlapped.

## Operation
- 16-bit free-running `now` counter; wraps; comparisons use equality only.
- On `cas_rdy`, push {req, due, bl2} into the queue:
  - due = now + AL + CL for reads.
  - due = now + AL + CWL for writes.
  - bl2 = BL/2.
- If the queue is full, drop the command and set `err_ovf`.
- FSM states: D_IDLE, D_WAIT, D_RD_BURST, D_WR_BURST.
  - D_IDLE: leave when the queue is non-empty and go to D_WAIT.
  - D_WAIT: when `now == head.due`, pop the head and enter the matching burst state with beat counter = 0.
    - Write: `wr_pop` and `dqs_oe` assert one cycle early, at `now == head.due - 1`.
  - D_RD_BURST: register `dq_in` into `rd_data`; `rd_valid` is high for bl2 cycles.
  - D_WR_BURST: `dq_out` = `wr_data`, `dq_oe` = 1; `wr_pop` is high for the first bl2-1 burst cycles.
  - On the last beat, `rw_done` = 1. Next state:
    - If the next head's due = now+1: go straight to its burst state (seamless).
    - Else if the queue is non-empty: D_WAIT.
    - Else: D_IDLE.
- Collision: if the head's due falls strictly inside the current burst, set `err_col`. That entry is discarded at pop time with no burst and no `rw_done`.
- Read-to-write and write-to-read turnaround spacing belongs to the CAS scheduler. This block does not check it beyond `err_col`.
- Auto-precharge variants (RDA_R/WRA_R) behave exactly as RD_R/WR_R here.

## Timing
- `cas_rdy` sampled at edge T; RL = AL+CL, WL = AL+CWL. Both must be ≥ 2; smaller values are unsupported.
- Read: `dq_in` is sampled at edges T+RL+k, k = 0..bl2-1. `rd_valid`/`rd_data` are valid in cycle T+RL+k+1. `rw_done` coincides with the last `rd_valid`.
- Write:
  - `wr_pop` high in cycles T+WL-1+k, k = 0..bl2-1.
  - `dq_out`/`dq_oe` high in cycles T+WL+k.
  - `dqs_oe` high in cycles T+WL-1 through T+WL+bl2-1.
  - `rw_done` in cycle T+WL+bl2-1.
- Push and pop in the same cycle is legal, including when full (pop frees the slot first).
- Reset values: all outputs 0, queue empty, `now` = 0, state D_IDLE, sticky errors cleared. Reset mid-burst aborts it the next cycle with no `rw_done`.

## Structure
- Add to `ddr_pkg`:
  - `data_fsm_type` {D_IDLE, D_WAIT, D_RD_BURST, D_WR_BURST}.
  - `DATA_Q_DEPTH = 4`.
  - Reuse the RD_R/RDA_R/WR_R/WRA_R encodings already there.
- One sub-module, `data_cmd_fifo`: synchronous FIFO of {req[2:0], due[15:0], bl2[2:0]} with push/pop/full/empty and same-cycle push+pop.

## Test plan
- CL=5, AL=0, BL=8, RD_R at T=10 → `dq_in` sampled at edges 15–18; `rd_valid` in cycles 16–19; `rw_done` in cycle 19 only.
- CWL=5, AL=0, BL=8, WR_R at T=10 → `dqs_oe` in cycles 14–18, `wr_pop` in 14–17, `dq_oe` in 15–18, `rw_done` in 18.
- Two RD_R at T=10 and T=14 (tCCD=4), CL=5, BL=8 → seamless `rd_valid` in cycles 16–23; `rw_done` at 19 and 23; `err_col` stays 0.
- Five `cas_rdy` pulses 1 cycle apart with CL=11 → `q_full` high after the fourth; fifth sets `err_ovf`; exactly four `rw_done` pulses.
- RD_R at T=10 and T=12, CL=5, BL=8 → `err_col` set; second burst discarded; one `rw_done`.
- `reset` asserted in cycle 17 of a write burst → `dq_oe`/`dqs_oe` low from cycle 18; no `rw_done`; queue empty.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared DDR controller types: CAS request encodings and data-phase
// FSM states, plus the pending data-command record.
package ddr_pkg;
  localparam logic [2:0] RD_R  = 3'd1;
  localparam logic [2:0] RDA_R = 3'd2;
  localparam logic [2:0] WR_R  = 3'd3;
  localparam logic [2:0] WRA_R = 3'd4;

  localparam int DATA_Q_DEPTH = 4;

  typedef enum logic [1:0] {
    D_IDLE,
    D_WAIT,
    D_RD_BURST,
    D_WR_BURST
  } data_fsm_type;

  typedef struct packed {
    logic [2:0]  req;
    logic [15:0] due;
    logic [2:0]  bl2;
  } data_cmd_t;

  function automatic logic is_wr(input logic [2:0] req);
    return (req == WR_R) || (req == WRA_R);
  endfunction
endpackage

// File: rtl/data_cmd_fifo.sv
// Pending data-command FIFO; a pop frees its slot for a push in the
// same cycle. Ports: clk/reset, push/push_data, pop, head, full, empty.
module data_cmd_fifo
  import ddr_pkg::*;
#(
  parameter int DEPTH = DATA_Q_DEPTH
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  data_cmd_t push_data,
  input  logic      pop,
  output data_cmd_t head,
  output logic      full,
  output logic      empty
);
  localparam int AW = $clog2(DEPTH);

  data_cmd_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/ctrl_burst_data.sv
// DDR data-phase engine: queues CAS commands, waits AL+CL / AL+CWL,
// then captures (rd_*) or drives (dq_*, dqs_oe, wr_pop) one burst.
module ctrl_burst_data
  import ddr_pkg::*;
#(
  parameter int DQ_W    = 8,
  parameter int Q_DEPTH = DATA_Q_DEPTH
) (
  input  logic              CK_t,
  input  logic              reset,
  input  logic              cas_rdy,
  input  logic [2:0]        cas_req,
  input  logic [4:0]        CL,
  input  logic [4:0]        CWL,
  input  logic [4:0]        AL,
  input  logic [3:0]        BL,
  input  logic [2*DQ_W-1:0] dq_in,
  input  logic [2*DQ_W-1:0] wr_data,
  output logic [2*DQ_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              wr_pop,
  output logic [2*DQ_W-1:0] dq_out,
  output logic              dq_oe,
  output logic              dqs_oe,
  output logic              rw_done,
  output logic              q_full,
  output logic              err_ovf,
  output logic              err_col
);
  data_fsm_type state;
  logic [15:0]  now;
  logic [15:0]  lat;
  logic [2:0]   beat;
  logic [2:0]   bl2_cur;
  logic         rd_done;
  data_cmd_t    push_data;
  data_cmd_t    head;
  logic         empty;
  logic         full;
  logic         pop;
  logic         in_burst;
  logic         last;
  logic         start;
  logic         take;
  logic         collide;
  logic         pre_wr;
  logic         unused_bl0;

  assign unused_bl0 = BL[0];

  assign lat = 16'(AL) +
    16'(is_wr(cas_req) ? CWL : CL);

  always_comb begin
    push_data     = '0;
    push_data.req = cas_req;
    push_data.due = now + lat;
    push_data.bl2 = BL[3:1];
  end

  data_cmd_fifo #(.DEPTH(Q_DEPTH)) u_fifo (
    .clk       (CK_t),
    .reset     (reset),
    .push      (cas_rdy),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty)
  );

  // The head is acted on one cycle ahead of its due cycle so the burst
  // state is already current when its first beat arrives.
  assign in_burst = (state == D_RD_BURST) ||
                    (state == D_WR_BURST);
  assign last     = in_burst &&
                    (beat == bl2_cur - 3'd1);
  assign start    = !empty &&
                    (head.due == now + 16'd1);
  assign take     = start && (!in_burst || last);
  // A head due mid-burst is dropped on the spot.
  assign collide  = start && in_burst && !last;
  assign pop      = start;
  assign pre_wr   = take && is_wr(head.req);

  assign q_full  = full;
  assign dq_oe   = state == D_WR_BURST;
  assign dq_out  = dq_oe ? wr_data : '0;
  assign wr_pop  = (dq_oe && !last) || pre_wr;
  assign dqs_oe  = dq_oe || pre_wr;
  assign rw_done = rd_done || (dq_oe && last);

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state    <= D_IDLE;
      now      <= '0;
      beat     <= '0;
      bl2_cur  <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
      rd_done  <= 1'b0;
      err_ovf  <= 1'b0;
      err_col  <= 1'b0;
    end else begin
      now      <= now + 16'd1;
      rd_valid <= state == D_RD_BURST;
      rd_done  <= (state == D_RD_BURST) && last;
      if (state == D_RD_BURST) rd_data <= dq_in;
      if (cas_rdy && full && !pop) err_ovf <= 1'b1;
      if (collide) err_col <= 1'b1;
      if (take) begin
        state   <= is_wr(head.req) ?
                   D_WR_BURST : D_RD_BURST;
        beat    <= '0;
        bl2_cur <= head.bl2;
      end else if (in_burst && !last) begin
        beat <= beat + 3'd1;
      end else begin
        state <= (!empty || cas_rdy) ?
                 D_WAIT : D_IDLE;
      end
    end
  end
endmodule

// File: tb/tb_ctrl_burst_data.sv
// Bench for ctrl_burst_data: directed latency cases, then random
// command streams scored against a per-cycle schedule model.
module tb_ctrl_burst_data;
  import ddr_pkg::*;

  localparam int DQ_W = 8;
  localparam int N    = 8192;
  localparam int QD   = DATA_Q_DEPTH;

  logic        CK_t = 1'b0;
  logic        reset = 1'b1;
  logic        cas_rdy = 1'b0;
  logic [2:0]  cas_req = '0;
  logic [4:0]  CL = '0, CWL = '0, AL = '0;
  logic [3:0]  BL = '0;
  logic [15:0] dq_in = '0, wr_data = '0;
  logic [15:0] rd_data, dq_out;
  logic        rd_valid, wr_pop, dq_oe, dqs_oe;
  logic        rw_done, q_full, err_ovf, err_col;

  ctrl_burst_data #(.DQ_W(DQ_W), .Q_DEPTH(QD)) dut (
    .CK_t(CK_t), .reset(reset), .cas_rdy(cas_rdy),
    .cas_req(cas_req), .CL(CL), .CWL(CWL), .AL(AL),
    .BL(BL), .dq_in(dq_in), .wr_data(wr_data),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .wr_pop(wr_pop), .dq_out(dq_out), .dq_oe(dq_oe),
    .dqs_oe(dqs_oe), .rw_done(rw_done),
    .q_full(q_full), .err_ovf(err_ovf),
    .err_col(err_col)
  );

  always #5 CK_t = ~CK_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int base = 0;
  bit chk_en = 1'b0;

  // expected per-cycle outputs, indexed by cycle
  bit e_rdv [N], e_pop [N], e_oe [N], e_dqs [N];
  bit e_done [N], e_ovf [N], e_col [N];
  int e_src [N], e_wix [N], occ [N], popc [N];
  logic [15:0] dq_hist [N];
  int last_end = 0;
  int wcount = 0;
  int host_n = 0;
  logic [15:0] wr_nx = '0;
  logic [7:0] s_flags;
  bit s_pop;
  int q_done[$], q_rdv[$], q_pop[$];
  int q_oe[$], q_dqs[$], q_full_c[$];

  function automatic logic [15:0] word(input int n);
    return 16'(n * 40503) ^ 16'h5a5a;
  endfunction

  function automatic int qf(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int ql(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h want %0h",
               nm, cyc, got, exp);
    end
  endtask

  always @(negedge CK_t) begin
    if (chk_en) begin
      chk("rd_valid", rd_valid, e_rdv[cyc]);
      chk("wr_pop", wr_pop, e_pop[cyc]);
      chk("dq_oe", dq_oe, e_oe[cyc]);
      chk("dqs_oe", dqs_oe, e_dqs[cyc]);
      chk("rw_done", rw_done, e_done[cyc]);
      chk("q_full", q_full, occ[cyc] >= QD);
      chk("err_ovf", err_ovf, e_ovf[cyc]);
      chk("err_col", err_col, e_col[cyc]);
      if (e_rdv[cyc])
        chk("rd_data", rd_data, dq_hist[e_src[cyc]]);
      if (e_oe[cyc])
        chk("dq_out", dq_out, word(e_wix[cyc]));
    end
  end

  task automatic clear_model(input int c);
    for (int i = c + 1; i < N; i++) begin
      e_rdv[i] = 0; e_pop[i] = 0; e_oe[i] = 0;
      e_dqs[i] = 0; e_done[i] = 0; e_ovf[i] = 0;
      e_col[i] = 0; occ[i] = 0; popc[i] = 0;
    end
    last_end = 0;
    wcount = host_n;
  endtask

  // command sampled at edge t: queue it, score drop/collision,
  // or lay out its whole burst in the expectation arrays
  task automatic accept(input int t);
    int lat, b2, d;
    bit wr;
    wr  = is_wr(cas_req);
    lat = int'(AL) + (wr ? int'(CWL) : int'(CL));
    b2  = int'(BL) / 2;
    d   = t + lat;
    if (occ[t] - popc[t] >= QD) begin
      for (int i = t + 1; i < N; i++) e_ovf[i] = 1;
      return;
    end
    for (int i = t + 1; i < d; i++) occ[i]++;
    popc[d-1]++;
    if (d < last_end) begin
      for (int i = d; i < N; i++) e_col[i] = 1;
      return;
    end
    last_end = d + b2;
    for (int k = 0; k < b2; k++) begin
      if (wr) begin
        e_pop[d-1+k] = 1;
        e_oe[d+k]    = 1;
        e_wix[d+k]   = wcount;
        wcount++;
      end else begin
        e_rdv[d+k+1] = 1;
        e_src[d+k+1] = d + k;
      end
    end
    if (wr) begin
      for (int i = d - 1; i < d + b2; i++) e_dqs[i] = 1;
      e_done[d+b2-1] = 1;
    end else begin
      e_done[d+b2] = 1;
    end
  endtask

  task automatic tick();
    @(negedge CK_t);
    s_pop   = wr_pop;
    s_flags = {rd_valid, wr_pop, dq_oe, dqs_oe,
               rw_done, q_full, err_ovf, err_col};
    if (rw_done)  q_done.push_back(cyc - base);
    if (rd_valid) q_rdv.push_back(cyc - base);
    if (wr_pop)   q_pop.push_back(cyc - base);
    if (dq_oe)    q_oe.push_back(cyc - base);
    if (dqs_oe)   q_dqs.push_back(cyc - base);
    if (q_full)   q_full_c.push_back(cyc - base);
    @(posedge CK_t);
    dq_hist[cyc] = dq_in;
    if (s_pop) begin
      wr_nx = word(host_n);
      host_n++;
    end
    if (reset) clear_model(cyc);
    else if (cas_rdy) accept(cyc);
    #1;
    wr_data = wr_nx;
    cyc++;
    cas_rdy = 1'b0;
    cas_req = 3'($urandom);
    CL  = 5'($urandom);
    CWL = 5'($urandom);
    AL  = 5'($urandom);
    BL  = 4'($urandom);
    dq_in = 16'($urandom);
  endtask

  task automatic cas(input logic [2:0] rq, input int al,
                     input int cl, input int cwl,
                     input int bl);
    cas_rdy = 1'b1;
    cas_req = rq;
    AL  = 5'(al);
    CL  = 5'(cl);
    CWL = 5'(cwl);
    BL  = 4'(bl);
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    chk_en = 1'b1;
    tick();
    chk("reset_outs", s_flags, 8'h00);
    reset = 1'b0;
    base = cyc;
    q_done = {}; q_rdv = {}; q_pop = {};
    q_oe = {}; q_dqs = {}; q_full_c = {};
  endtask

  task automatic wait_until(input int rel);
    while (cyc < base + rel) tick();
  endtask

  task automatic rand_phase(input int ncyc);
    logic [2:0] rq;
    int b2, need, l, lo, hi, al, c;
    for (int i = 0; i < ncyc; i++) begin
      if ($urandom_range(0, 3) == 0 && cyc < N - 200) begin
        rq   = 3'($urandom_range(1, 4));
        b2   = $urandom_range(0, 1) ? 8 : 4;
        need = last_end - cyc;
        if (need < 2) need = 2;
        if (need <= 40) begin
          l  = need + $urandom_range(0, 6);
          lo = (l > 31) ? l - 31 : 0;
          hi = (l < 12) ? l : 12;
          if (hi < lo) hi = lo;
          al = $urandom_range(lo, hi);
          c  = l - al;
          if (is_wr(rq))
            cas(rq, al, $urandom_range(0, 31), c, b2);
          else
            cas(rq, al, c, $urandom_range(0, 31), b2);
        end else begin
          tick();
        end
      end else begin
        tick();
      end
    end
  endtask

  initial begin
    // single read, CL=5, BL=8
    do_reset();
    wait_until(10);
    cas(RD_R, 0, 5, 9, 8);
    wait_until(30);
    chk("t1_rdv_first", qf(q_rdv), 16);
    chk("t1_rdv_last", ql(q_rdv), 19);
    chk("t1_rdv_n", q_rdv.size(), 4);
    chk("t1_done_n", q_done.size(), 1);
    chk("t1_done_at", qf(q_done), 19);

    // single write, CWL=5, BL=8
    do_reset();
    wait_until(10);
    cas(WR_R, 0, 9, 5, 8);
    wait_until(30);
    chk("t2_dqs_first", qf(q_dqs), 14);
    chk("t2_dqs_last", ql(q_dqs), 18);
    chk("t2_pop_first", qf(q_pop), 14);
    chk("t2_pop_last", ql(q_pop), 17);
    chk("t2_oe_first", qf(q_oe), 15);
    chk("t2_oe_last", ql(q_oe), 18);
    chk("t2_done_at", qf(q_done), 18);
    chk("t2_done_n", q_done.size(), 1);

    // seamless reads at tCCD=4
    do_reset();
    wait_until(10);
    cas(RD_R, 0, 5, 5, 8);
    wait_until(14);
    cas(RDA_R, 0, 5, 5, 8);
    wait_until(34);
    chk("t3_rdv_n", q_rdv.size(), 8);
    chk("t3_rdv_first", qf(q_rdv), 16);
    chk("t3_rdv_last", ql(q_rdv), 23);
    chk("t3_done_n", q_done.size(), 2);
    chk("t3_done_1", qf(q_done), 19);
    chk("t3_done_2", ql(q_done), 23);
    chk("t3_col", s_flags[0], 1'b0);

    // five back-to-back commands into a 4-deep queue
    do_reset();
    wait_until(10);
    cas(RD_R, 0, 11, 5, 8);
    cas(RD_R, 0, 14, 5, 8);
    cas(RD_R, 0, 17, 5, 8);
    cas(RD_R, 0, 20, 5, 8);
    cas(RD_R, 0, 23, 5, 8);
    wait_until(50);
    chk("t4_full_first", qf(q_full_c), 14);
    chk("t4_ovf", s_flags[1], 1'b1);
    chk("t4_done_n", q_done.size(), 4);
    chk("t4_done_1", qf(q_done), 25);

    // overlapping reads: second one discarded
    do_reset();
    wait_until(10);
    cas(RD_R, 0, 5, 5, 8);
    wait_until(12);
    cas(RD_R, 0, 5, 5, 8);
    wait_until(30);
    chk("t5_col", s_flags[0], 1'b1);
    chk("t5_done_n", q_done.size(), 1);
    chk("t5_done_at", qf(q_done), 19);
    chk("t5_rdv_n", q_rdv.size(), 4);

    // reset in the middle of a write burst
    do_reset();
    wait_until(10);
    cas(WR_R, 0, 5, 5, 8);
    wait_until(17);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    wait_until(30);
    chk("t6_oe_last", ql(q_oe), 17);
    chk("t6_dqs_last", ql(q_dqs), 17);
    chk("t6_done_n", q_done.size(), 0);
    chk("t6_flags", s_flags, 8'h00);

    // randomized traffic
    do_reset();
    rand_phase(2500);
    wait_until(cyc - base + 80);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
